// File: rtl/universal_shift_register_p_pkg.sv
// Shared definitions for the parametrised universal shift register: operation
// modes, FSM state encoding and the mode field width.
package usr_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD = 3'b000,
    MODE_SHR  = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_ROL  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_e;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_BUSY = 1'b1;

endpackage

// File: rtl/universal_shift_register_p_step.sv
// Combinational next-value logic for one register step, shared by the
// single-step and burst paths.
module usr_step_core
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]  cur,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  parin,
  input  logic              sin_msb,
  input  logic              sin_lsb,
  output logic [WIDTH-1:0]  nxt,
  output logic              sout_nxt,
  output logic              sout_upd
);

  logic signed [WIDTH-1:0] cur_s;

  assign cur_s = cur;

  always_comb begin
    nxt      = cur;
    sout_nxt = 1'b0;
    sout_upd = 1'b0;
    case (mode)
      MODE_SHR: begin
        nxt      = {sin_msb, cur[WIDTH-1:1]};
        sout_nxt = cur[0];
        sout_upd = 1'b1;
      end
      MODE_SHL: begin
        nxt      = {cur[WIDTH-2:0], sin_lsb};
        sout_nxt = cur[WIDTH-1];
        sout_upd = 1'b1;
      end
      MODE_LOAD: begin
        nxt = parin;
      end
      MODE_ROR: begin
        nxt      = {cur[0], cur[WIDTH-1:1]};
        sout_nxt = cur[0];
        sout_upd = 1'b1;
      end
      MODE_ROL: begin
        nxt      = {cur[WIDTH-2:0], cur[WIDTH-1]};
        sout_nxt = cur[WIDTH-1];
        sout_upd = 1'b1;
      end
      MODE_ASR: begin
        nxt      = cur_s >>> 1;
        sout_nxt = cur[0];
        sout_upd = 1'b1;
      end
      default: begin
        nxt = cur;
      end
    endcase
  end

endmodule

// File: rtl/universal_shift_register_p.sv
// Universal shift register with single-step operation and a burst engine that
// repeats a latched mode for a programmed number of cycles.
module universal_shift_register_p
  import usr_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = WIDTH,
  parameter int CW        = $clog2(MAX_COUNT + 1)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  parin,
  input  logic              sin_msb,
  input  logic              sin_lsb,
  input  logic              start,
  input  logic [CW-1:0]     count,
  output logic [WIDTH-1:0]  out,
  output logic              sout,
  output logic              busy,
  output logic              done
);

  localparam logic [CW-1:0] MAXC = CW'(MAX_COUNT);

  function automatic logic [CW-1:0] sat_count(input logic [CW-1:0] c);
    return (c > MAXC) ? MAXC : c;
  endfunction

  state_t              state_p0;
  logic [WIDTH-1:0]    shreg_p0;
  logic                sout_p0;
  logic                done_p0;
  logic [CW-1:0]       cnt_p0;
  logic [MODE_W-1:0]   mode_p0;
  logic [WIDTH-1:0]    parin_p0;

  logic [MODE_W-1:0]   step_mode;
  logic [WIDTH-1:0]    step_parin;
  logic [WIDTH-1:0]    step_nxt;
  logic                step_sout;
  logic                step_sout_upd;
  logic [CW-1:0]       cnt_sat;

  // While busy, the step core sees only the values captured at burst start.
  assign step_mode  = (state_p0 == ST_BUSY) ? mode_p0  : mode;
  assign step_parin = (state_p0 == ST_BUSY) ? parin_p0 : parin;
  assign cnt_sat    = sat_count(count);

  usr_step_core #(
    .WIDTH (WIDTH)
  ) u_step (
    .cur      (shreg_p0),
    .mode     (step_mode),
    .parin    (step_parin),
    .sin_msb  (sin_msb),
    .sin_lsb  (sin_lsb),
    .nxt      (step_nxt),
    .sout_nxt (step_sout),
    .sout_upd (step_sout_upd)
  );

  // Stage p0: register, serial-out, FSM and burst counter
  always_ff @(posedge clk) begin
    if (clr) begin
      state_p0 <= ST_IDLE;
      shreg_p0 <= '0;
      sout_p0  <= 1'b0;
      done_p0  <= 1'b0;
      cnt_p0   <= '0;
      mode_p0  <= MODE_HOLD;
      parin_p0 <= '0;
    end else begin
      done_p0 <= 1'b0;
      case (state_p0)
        ST_IDLE: begin
          if (start) begin
            if (cnt_sat == '0) begin
              done_p0 <= 1'b1;
            end else begin
              state_p0 <= ST_BUSY;
              cnt_p0   <= cnt_sat;
              mode_p0  <= mode;
              parin_p0 <= parin;
            end
          end else if (en) begin
            shreg_p0 <= step_nxt;
            if (step_sout_upd) sout_p0 <= step_sout;
          end
        end
        default: begin
          shreg_p0 <= step_nxt;
          if (step_sout_upd) sout_p0 <= step_sout;
          cnt_p0 <= cnt_p0 - 1'b1;
          if (cnt_p0 == CW'(1)) begin
            state_p0 <= ST_IDLE;
            done_p0  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign out  = shreg_p0;
  assign sout = sout_p0;
  assign busy = (state_p0 == ST_BUSY);
  assign done = done_p0;

endmodule

// File: tb/tb_universal_shift_register_p.sv
// Directed bench for universal_shift_register_p at WIDTH=4 with a queue of
// expected register/status values checked one cycle after each drive.
module tb_universal_shift_register_p;
  import usr_pkg::*;

  localparam int WIDTH = 4;
  localparam int CW    = $clog2(WIDTH + 1);

  logic              clk = 1'b0;
  logic              clr;
  logic              en;
  logic [MODE_W-1:0] mode;
  logic [WIDTH-1:0]  parin;
  logic              sin_msb;
  logic              sin_lsb;
  logic              start;
  logic [CW-1:0]     count;
  logic [WIDTH-1:0]  out;
  logic              sout;
  logic              busy;
  logic              done;

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] o;
    logic             s;
    logic             b;
    logic             d;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  universal_shift_register_p #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .clr     (clr),
    .en      (en),
    .mode    (mode),
    .parin   (parin),
    .sin_msb (sin_msb),
    .sin_lsb (sin_lsb),
    .start   (start),
    .count   (count),
    .out     (out),
    .sout    (sout),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Push the expectation for the coming edge, clock once, then pop and compare.
  task automatic tick(input string tag, input logic [WIDTH-1:0] o,
                      input logic s, input logic b, input logic d);
    exp_t e;
    sb.push_back('{tag: tag, o: o, s: s, b: b, d: d});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".out"},  32'(out),  32'(e.o));
      chk({e.tag, ".sout"}, 32'(sout), 32'(e.s));
      chk({e.tag, ".busy"}, 32'(busy), 32'(e.b));
      chk({e.tag, ".done"}, 32'(done), 32'(e.d));
    end
  endtask

  initial begin
    clr = 1'b1; en = 1'b0; mode = MODE_HOLD; parin = '0;
    sin_msb = 1'b0; sin_lsb = 1'b0; start = 1'b0; count = '0;

    // Reset with random activity on every other input
    for (int i = 0; i < 2; i++) begin
      en = 1'($urandom); mode = 3'($urandom); parin = 4'($urandom);
      sin_msb = 1'($urandom); sin_lsb = 1'($urandom);
      start = 1'($urandom); count = 3'($urandom_range(1, 4));
      tick("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    end
    clr = 1'b0; start = 1'b0; en = 1'b0; sin_msb = 1'b0; sin_lsb = 1'b0;

    // Single-step modes
    en = 1'b1; mode = MODE_LOAD; parin = 4'b1011;
    tick("load", 4'b1011, 1'b0, 1'b0, 1'b0);
    mode = MODE_SHR; sin_msb = 1'b0;
    tick("shr", 4'b0101, 1'b1, 1'b0, 1'b0);
    mode = MODE_SHL; sin_lsb = 1'b1;
    tick("shl", 4'b1011, 1'b0, 1'b0, 1'b0);
    mode = MODE_ROR;
    tick("ror", 4'b1101, 1'b1, 1'b0, 1'b0);
    mode = MODE_ROL;
    tick("rol", 4'b1011, 1'b1, 1'b0, 1'b0);
    mode = MODE_ASR;
    tick("asr1", 4'b1101, 1'b1, 1'b0, 1'b0);
    tick("asr2", 4'b1110, 1'b1, 1'b0, 1'b0);
    en = 1'b0; mode = MODE_SHR;
    tick("en_low", 4'b1110, 1'b1, 1'b0, 1'b0);
    en = 1'b1; mode = MODE_RSVD;
    tick("reserved", 4'b1110, 1'b1, 1'b0, 1'b0);
    mode = MODE_LOAD; parin = 4'b1000;
    tick("load1000", 4'b1000, 1'b1, 1'b0, 1'b0);

    // ROL burst of 3 with en/mode/parin toggled while busy
    en = 1'b0; start = 1'b1; mode = MODE_ROL; count = 3'd3;
    tick("rol_b.e0", 4'b1000, 1'b1, 1'b1, 1'b0);
    start = 1'b0; en = 1'b1; mode = MODE_SHR; parin = 4'b0110;
    tick("rol_b.e1", 4'b0001, 1'b1, 1'b1, 1'b0);
    mode = MODE_LOAD; en = 1'b0;
    tick("rol_b.e2", 4'b0010, 1'b0, 1'b1, 1'b0);
    en = 1'b1; start = 1'b1; count = 3'd0;
    tick("rol_b.e3", 4'b0100, 1'b0, 1'b0, 1'b1);
    start = 1'b0; en = 1'b0;
    tick("rol_b.after", 4'b0100, 1'b0, 1'b0, 1'b0);

    // Zero-length start takes priority over en=1 LOAD
    start = 1'b1; count = 3'd0; en = 1'b1; mode = MODE_LOAD; parin = 4'b1111;
    tick("zero.e0", 4'b0100, 1'b0, 1'b0, 1'b1);
    start = 1'b0; en = 1'b0;
    tick("zero.e1", 4'b0100, 1'b0, 1'b0, 1'b0);

    // Oversized count saturates to 4 SHR steps with sin_msb=1
    start = 1'b1; count = 3'd7; mode = MODE_SHR; sin_msb = 1'b1;
    tick("sat.e0", 4'b0100, 1'b0, 1'b1, 1'b0);
    start = 1'b0; mode = MODE_HOLD;
    tick("sat.e1", 4'b1010, 1'b0, 1'b1, 1'b0);
    tick("sat.e2", 4'b1101, 1'b0, 1'b1, 1'b0);
    tick("sat.e3", 4'b1110, 1'b1, 1'b1, 1'b0);
    tick("sat.e4", 4'b1111, 1'b0, 1'b0, 1'b1);
    tick("sat.after", 4'b1111, 1'b0, 1'b0, 1'b0);

    // Burst aborted by clr at step 2 of 4
    en = 1'b1; mode = MODE_LOAD; parin = 4'b0110; sin_msb = 1'b0;
    tick("abort.load", 4'b0110, 1'b0, 1'b0, 1'b0);
    en = 1'b0; start = 1'b1; mode = MODE_SHL; count = 3'd4; sin_lsb = 1'b0;
    tick("abort.e0", 4'b0110, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    tick("abort.e1", 4'b1100, 1'b0, 1'b1, 1'b0);
    clr = 1'b1;
    tick("abort.clr", 4'b0000, 1'b0, 1'b0, 1'b0);
    clr = 1'b0;
    tick("abort.post1", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick("abort.post2", 4'b0000, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/universal_shift_register_p.md
Name: universal_shift_register_p

Overview:
Parametrised successor to the 4-bit universal shift register. Adds a configurable width, rotate and arithmetic-shift modes, serial in/out on both ends, and a burst engine that applies one mode for N consecutive cycles with busy/done status. It sits in the datapath utilities layer and serves serialisers, barrel-less multi-bit shifts and CRC/LFSR staging.

Parameters:
WIDTH, 4, register width in bits (>=2)
MAX_COUNT, WIDTH, maximum burst length
CW, $clog2(MAX_COUNT+1), width of the burst count port (derived; do not override)

Ports:
clk  in  1  rising-edge clock
clr  in  1  synchronous active-high reset
en  in  1  single-step enable (idle only)
mode  in  3  operation select (see Behaviour)
parin  in  WIDTH  parallel load data
sin_msb  in  1  serial input entering at MSB on shift-right
sin_lsb  in  1  serial input entering at LSB on shift-left
start  in  1  burst request pulse
count  in  CW  burst length; values >MAX_COUNT saturate to MAX_COUNT
out  out  WIDTH  register contents
sout  out  1  bit expelled (or wrapped) by the most recent shift/rotate
busy  out  1  burst in progress
done  out  1  one-cycle burst-complete pulse

Behaviour:
- Modes: 000 HOLD; 001 SHR (out <= {sin_msb, out[W-1:1]}, sout <= out[0]); 010 SHL (out <= {out[W-2:0], sin_lsb}, sout <= out[W-1]); 011 LOAD (out <= parin, sout unchanged); 100 ROR (sout <= out[0]); 101 ROL (sout <= out[W-1]); 110 ASR (MSB replicated, sout <= out[0]); 111 reserved, behaves as HOLD.
- Reset: clr sampled high -> out=0, sout=0, busy=0, done=0, state IDLE, counter=0. clr overrides all other inputs, including mid-burst; any burst in progress is aborted with no done pulse.
- FSM states: IDLE, BUSY.
- IDLE, start=1, saturated count>0: latch mode and count, go to BUSY, busy=1 from the next cycle, no shift on this edge.
- IDLE, start=1, count=0: stay in IDLE, no change to out, done=1 for the next cycle only.
- IDLE, start=0, en=1: apply mode once; out and sout update at that edge (1-cycle latency).
- IDLE, start=0, en=0: hold.
- start has priority over en.
- BUSY: on each edge, apply the latched mode and decrement the counter. On the edge that applies the final step: go to IDLE, busy=0, and done=1 for the next cycle.
- A burst of N therefore shifts at edges E1..EN after the start edge E0. busy is high in cycles E0..E(N-1)+; done is high in the cycle following EN.
- Burst with LOAD reloads the latched-at-start parin every step. Net effect is a single load.
- While BUSY, en, mode, parin and start are ignored. The serial inputs are still sampled live on every step.
- done is never high while busy is high. done deasserts after one cycle unless a new count=0 start re-asserts it.

Decomposition:
- Package usr_pkg: mode localparams/enum (MODE_HOLD..MODE_ASR), the FSM state enum, and the mode field width constant 3.
- One combinational sub-module, usr_step_core: (cur, mode, parin, sin_msb, sin_lsb) -> (nxt, sout_nxt, sout_upd). It is shared by the single-step and burst paths.
- The top level holds the FSM, counter, latched mode/parin, and registers.

Test Plan:
- WIDTH=4. clr=1 for 2 cycles with random inputs -> out=0000, sout=0, busy=0, done=0.
- en=1, LOAD parin=1011 -> out=1011 next cycle. Then SHR with sin_msb=0 -> 0101, sout=1. Then SHL with sin_lsb=1 -> 1011, sout=0.
- From out=1011: ROR -> 1101, sout=1. ROL -> 1011, sout=1. ASR -> 1101, then 1110, sign preserved.
- Load 1000, then start with mode=ROL, count=3 -> busy high for 3 step cycles, out=0100 after the last step, done pulses 1 cycle, busy=0 in the done cycle.
- start with count=0 -> out unchanged, done=1 for exactly 1 cycle, busy never asserted. count=7 at WIDTH=4 -> saturates to 4 steps.
- Mid-burst (step 2 of 4): clr=1 -> out=0000, busy=0, no done pulse. Toggling en/mode during a burst -> no effect on the result.
